wired_mdu_div_issue: RTL and testbench
======================================

// Module: wired_mdu_div_issue
// PURPOSE
//  Initiator side of the MDU divide request/response interface. Buffers divide ops from
//  dispatch in order and issues them to the divider execution unit (req: op/wid/r0/r1)
//  with valid/ready. Collects divider responses (wid/result), checks them against in-flight
//  order, and drives a registered writeback slot toward the ROB/CDB. Flush clears all state.
// PARAMETERS
//  DEPTH    4  request FIFO entries (power of 2, >=2)
//  MAX_OUT  2  max issued-but-unanswered divides (>=1)
//  RID_W    6  ROB id (wid) width
// PORTS
//  clk           in   1      clock
//  rst_n         in   1      asynchronous active-low reset
//  flush_i       in   1      pipeline flush (synchronous effect)
//  disp_valid_i  in   1      dispatch offers a divide op
//  disp_ready_o  out  1      FIFO can accept
//  disp_op_i     in   2      [0]=unsigned, [1]=remainder (else quotient)
//  disp_wid_i    in   RID_W  destination ROB id
//  disp_r0_i     in   32     divisor
//  disp_r1_i     in   32     dividend
//  div_valid_o   out  1      request to divider valid
//  div_ready_i   in   1      divider accepts request
//  div_op_o      out  2      = head op
//  div_wid_o     out  RID_W  = head wid
//  div_r0_o      out  32     = head divisor
//  div_r1_o      out  32     = head dividend
//  rsp_valid_i   in   1      divider response valid
//  rsp_ready_o   out  1      response accepted
//  rsp_wid_i     in   RID_W  response ROB id
//  rsp_result_i  in   32     quotient or remainder
//  wb_valid_o    out  1      writeback slot valid
//  wb_ready_i    in   1      writeback consumer accepts
//  wb_wid_o      out  RID_W  writeback ROB id
//  wb_result_o   out  32     writeback data
//  err_o         out  1      sticky: response wid != oldest in-flight wid, or response with none in flight
// BEHAVIOUR
//  Reset (rst_n low, async): FIFO empty, out_cnt=0, wb slot empty, err_o=0; all valids 0.
//  Dispatch: disp_ready_o = (fifo count < DEPTH); push on disp_valid_i&disp_ready_o.
//   No same-cycle bypass: an op pushed in cycle N is visible on div_* no earlier than N+1.
//  Issue: div_valid_o = fifo nonempty && out_cnt < MAX_OUT; div_* = head entry (stable while
//   valid and not accepted). Fire = div_valid_o&div_ready_i: pop head, push wid into in-flight
//   tracker (MAX_OUT-deep FIFO), out_cnt+1.
//  Push and pop in same cycle when full: pop frees no slot that cycle (ready uses registered count).
//  Response: rsp_ready_o = !wb_valid_o || wb_ready_i. On rsp_valid_i&rsp_ready_o: load wb slot
//   {rsp_wid_i, rsp_result_i} (visible next cycle), pop tracker, out_cnt-1; if out_cnt==0 or
//   rsp_wid_i != tracker head, set err_o (slot still loaded; tracker/out_cnt not decremented below 0).
//  Issue fire and response in same cycle: out_cnt unchanged, tracker push+pop both occur.
//  Writeback: wb_valid_o set by response load; cleared on wb_ready_i with no new load;
//   wb_* held stable while wb_valid_o && !wb_ready_i.
//  Flush (flush_i high at clock edge): FIFO emptied, tracker emptied, out_cnt=0, wb slot cleared,
//   any dispatch push/issue fire/response in that cycle discarded; err_o retained.
//   div_valid_o and wb_valid_o are 0 the cycle after flush. Divider is flushed by the same signal.
//  Order: responses are in issue order (divider is in-order); wb order == dispatch order.
//  Counters wrap modulo DEPTH/MAX_OUT pointers; count registers are one bit wider than index.
// TESTING
//  1 reset mid-op: 3 ops queued, 1 issued, rst_n low -> next edge: all valids 0, err_o 0, disp_ready_o 1.
//  2 single op: wid=5, r1=100, r0=7, op=0 -> div_valid_o cycle+1; rsp {5,14} -> wb {5,14} next cycle.
//  3 backpressure: MAX_OUT=2, div_ready_i=1, no rsp -> 2 issues then div_valid_o=0; rsp frees one.
//  4 full FIFO: 4 pushes with div_ready_i=0 -> disp_ready_o=0; 5th offer held, no loss/reorder.
//  5 wb stall: wb_ready_i=0 with slot full -> rsp_ready_o=0, wb_* stable; release -> drains in order.
//  6 flush: 2 in flight, 2 queued, flush_i -> next cycle div_valid_o=0, wb_valid_o=0, out_cnt=0;
//    bad-order rsp (wid 3 when head 2) -> err_o=1 and stays 1.

Source files
------------

// File: rtl/wired_mdu_div_issue.sv
// Initiator side of the MDU divide interface: queues dispatched divide ops, issues them in
// order to the divider, checks responses against in-flight order and drives a writeback slot.
module wired_mdu_div_issue #(
   parameter int DEPTH   = 4,
   parameter int MAX_OUT = 2,
   parameter int RID_W   = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_i,
   input  logic             disp_valid_i,
   output logic             disp_ready_o,
   input  logic [1:0]       disp_op_i,
   input  logic [RID_W-1:0] disp_wid_i,
   input  logic [31:0]      disp_r0_i,
   input  logic [31:0]      disp_r1_i,
   output logic             div_valid_o,
   input  logic             div_ready_i,
   output logic [1:0]       div_op_o,
   output logic [RID_W-1:0] div_wid_o,
   output logic [31:0]      div_r0_o,
   output logic [31:0]      div_r1_o,
   input  logic             rsp_valid_i,
   output logic             rsp_ready_o,
   input  logic [RID_W-1:0] rsp_wid_i,
   input  logic [31:0]      rsp_result_i,
   output logic             wb_valid_o,
   input  logic             wb_ready_i,
   output logic [RID_W-1:0] wb_wid_o,
   output logic [31:0]      wb_result_o,
   output logic             err_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int TR_W  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam int OUT_W = $clog2(MAX_OUT + 1);

   localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
   localparam logic [OUT_W-1:0] MAX_OUT_C = OUT_W'(MAX_OUT);
   localparam logic [TR_W-1:0]  TR_LAST   = TR_W'(MAX_OUT - 1);

   logic [1:0]       q_op  [DEPTH];
   logic [RID_W-1:0] q_wid [DEPTH];
   logic [31:0]      q_r0  [DEPTH];
   logic [31:0]      q_r1  [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] fifo_cnt;

   logic [RID_W-1:0] tr_wid [MAX_OUT];
   logic [TR_W-1:0]  tr_wr;
   logic [TR_W-1:0]  tr_rd;
   logic [OUT_W-1:0] out_cnt;

   logic push;
   logic issue_fire;
   logic rsp_fire;
   logic rsp_pop;
   logic rsp_bad;
   logic tr_has;

   assign disp_ready_o = (fifo_cnt < DEPTH_C);
   assign push         = disp_valid_i & disp_ready_o;

   assign div_valid_o = (fifo_cnt != '0) && (out_cnt < MAX_OUT_C);
   assign issue_fire  = div_valid_o & div_ready_i;
   assign div_op_o    = q_op[rd_ptr];
   assign div_wid_o   = q_wid[rd_ptr];
   assign div_r0_o    = q_r0[rd_ptr];
   assign div_r1_o    = q_r1[rd_ptr];

   // A response with nothing in flight is still accepted and written back, but never pops.
   assign rsp_ready_o = !wb_valid_o || wb_ready_i;
   assign rsp_fire    = rsp_valid_i & rsp_ready_o;
   assign tr_has      = (out_cnt != '0);
   assign rsp_pop     = rsp_fire & tr_has;
   assign rsp_bad     = rsp_fire & (!tr_has || (rsp_wid_i != tr_wid[tr_rd]));

   // Payload storage carries no reset; only pointers and counts qualify it.
   always_ff @(posedge clk) begin
      if (push && !flush_i) begin
         q_op[wr_ptr]  <= disp_op_i;
         q_wid[wr_ptr] <= disp_wid_i;
         q_r0[wr_ptr]  <= disp_r0_i;
         q_r1[wr_ptr]  <= disp_r1_i;
      end
      if (issue_fire && !flush_i) begin
         tr_wid[tr_wr] <= div_wid_o;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else if (flush_i) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (issue_fire) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, issue_fire})
            2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
            2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // Tracker pointers wrap explicitly so MAX_OUT need not be a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tr_wr   <= '0;
         tr_rd   <= '0;
         out_cnt <= '0;
      end else if (flush_i) begin
         tr_wr   <= '0;
         tr_rd   <= '0;
         out_cnt <= '0;
      end else begin
         if (issue_fire) begin
            tr_wr <= (tr_wr == TR_LAST) ? '0 : tr_wr + TR_W'(1);
         end
         if (rsp_pop) begin
            tr_rd <= (tr_rd == TR_LAST) ? '0 : tr_rd + TR_W'(1);
         end
         case ({issue_fire, rsp_pop})
            2'b10:   out_cnt <= out_cnt + OUT_W'(1);
            2'b01:   out_cnt <= out_cnt - OUT_W'(1);
            default: out_cnt <= out_cnt;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid_o  <= 1'b0;
         wb_wid_o    <= '0;
         wb_result_o <= '0;
      end else if (flush_i) begin
         wb_valid_o <= 1'b0;
      end else if (rsp_fire) begin
         wb_valid_o  <= 1'b1;
         wb_wid_o    <= rsp_wid_i;
         wb_result_o <= rsp_result_i;
      end else if (wb_ready_i) begin
         wb_valid_o <= 1'b0;
      end
   end

   // Sticky order error survives flush; only reset clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_o <= 1'b0;
      end else if (!flush_i && rsp_bad) begin
         err_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_wired_mdu_div_issue.sv
// Directed bench for wired_mdu_div_issue: reset, single op, backpressure, full FIFO,
// writeback stall and flush/order-error scenarios with hand-computed expectations.
module tb_wired_mdu_div_issue;

   localparam int RID_W = 6;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             flush_i;
   logic             disp_valid_i;
   logic             disp_ready_o;
   logic [1:0]       disp_op_i;
   logic [RID_W-1:0] disp_wid_i;
   logic [31:0]      disp_r0_i;
   logic [31:0]      disp_r1_i;
   logic             div_valid_o;
   logic             div_ready_i;
   logic [1:0]       div_op_o;
   logic [RID_W-1:0] div_wid_o;
   logic [31:0]      div_r0_o;
   logic [31:0]      div_r1_o;
   logic             rsp_valid_i;
   logic             rsp_ready_o;
   logic [RID_W-1:0] rsp_wid_i;
   logic [31:0]      rsp_result_i;
   logic             wb_valid_o;
   logic             wb_ready_i;
   logic [RID_W-1:0] wb_wid_o;
   logic [31:0]      wb_result_o;
   logic             err_o;

   int vecs = 0;
   int errs = 0;

   wired_mdu_div_issue #(.DEPTH(4), .MAX_OUT(2), .RID_W(RID_W)) dut (
      .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
      .disp_valid_i(disp_valid_i), .disp_ready_o(disp_ready_o), .disp_op_i(disp_op_i),
      .disp_wid_i(disp_wid_i), .disp_r0_i(disp_r0_i), .disp_r1_i(disp_r1_i),
      .div_valid_o(div_valid_o), .div_ready_i(div_ready_i), .div_op_o(div_op_o),
      .div_wid_o(div_wid_o), .div_r0_o(div_r0_o), .div_r1_o(div_r1_o),
      .rsp_valid_i(rsp_valid_i), .rsp_ready_o(rsp_ready_o), .rsp_wid_i(rsp_wid_i),
      .rsp_result_i(rsp_result_i), .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
      .wb_wid_o(wb_wid_o), .wb_result_o(wb_result_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      flush_i = 1'b0; disp_valid_i = 1'b0; disp_op_i = 2'd0; disp_wid_i = '0;
      disp_r0_i = '0; disp_r1_i = '0; div_ready_i = 1'b0; rsp_valid_i = 1'b0;
      rsp_wid_i = '0; rsp_result_i = '0; wb_ready_i = 1'b0;
   endtask

   task automatic test_reset();
      vecs++; if (div_valid_o !== 1'b0 || wb_valid_o !== 1'b0 || err_o !== 1'b0 || disp_ready_o !== 1'b1) begin
         errs++; $display("[TB] FAIL init_reset: got div_v=%b wb_v=%b err=%b drdy=%b want 0 0 0 1", div_valid_o, wb_valid_o, err_o, disp_ready_o); end
      for (int i = 0; i < 3; i++) begin
         disp_valid_i = 1'b1; disp_wid_i = RID_W'(1 + i); disp_r0_i = 32'(i); disp_r1_i = 32'(i + 10);
         step();
      end
      disp_valid_i = 1'b0;
      vecs++; if (div_valid_o !== 1'b1 || div_wid_o !== 6'd1) begin
         errs++; $display("[TB] FAIL rst_pre_head: got v=%b wid=%0d want 1 1", div_valid_o, div_wid_o); end
      div_ready_i = 1'b1; step(); div_ready_i = 1'b0;
      vecs++; if (div_wid_o !== 6'd2) begin
         errs++; $display("[TB] FAIL rst_pre_issue: got wid=%0d want 2", div_wid_o); end
      rst_n = 1'b0; step();
      vecs++; if (div_valid_o !== 1'b0 || wb_valid_o !== 1'b0 || err_o !== 1'b0 || disp_ready_o !== 1'b1 || rsp_ready_o !== 1'b1) begin
         errs++; $display("[TB] FAIL mid_reset: got div_v=%b wb_v=%b err=%b drdy=%b rrdy=%b want 0 0 0 1 1", div_valid_o, wb_valid_o, err_o, disp_ready_o, rsp_ready_o); end
      rst_n = 1'b1; step();
      vecs++; if (div_valid_o !== 1'b0) begin
         errs++; $display("[TB] FAIL post_reset_empty: got div_v=%b want 0", div_valid_o); end
   endtask

   task automatic test_single_op();
      disp_valid_i = 1'b1; disp_wid_i = 6'd5; disp_r1_i = 32'd100; disp_r0_i = 32'd7; disp_op_i = 2'd0;
      #1;
      vecs++; if (div_valid_o !== 1'b0) begin
         errs++; $display("[TB] FAIL no_bypass: got div_v=%b want 0", div_valid_o); end
      step(); disp_valid_i = 1'b0;
      vecs++; if (div_valid_o !== 1'b1 || div_wid_o !== 6'd5 || div_r1_o !== 32'd100 || div_r0_o !== 32'd7 || div_op_o !== 2'd0) begin
         errs++; $display("[TB] FAIL single_req: got v=%b wid=%0d r1=%0d r0=%0d op=%0d want 1 5 100 7 0", div_valid_o, div_wid_o, div_r1_o, div_r0_o, div_op_o); end
      div_ready_i = 1'b1; step(); div_ready_i = 1'b0;
      vecs++; if (div_valid_o !== 1'b0) begin
         errs++; $display("[TB] FAIL single_popped: got div_v=%b want 0", div_valid_o); end
      rsp_valid_i = 1'b1; rsp_wid_i = 6'd5; rsp_result_i = 32'd14;
      #1;
      vecs++; if (rsp_ready_o !== 1'b1 || wb_valid_o !== 1'b0) begin
         errs++; $display("[TB] FAIL single_rsp_rdy: got rrdy=%b wb_v=%b want 1 0", rsp_ready_o, wb_valid_o); end
      step(); rsp_valid_i = 1'b0;
      vecs++; if (wb_valid_o !== 1'b1 || wb_wid_o !== 6'd5 || wb_result_o !== 32'd14 || err_o !== 1'b0) begin
         errs++; $display("[TB] FAIL single_wb: got v=%b wid=%0d res=%0d err=%b want 1 5 14 0", wb_valid_o, wb_wid_o, wb_result_o, err_o); end
      wb_ready_i = 1'b1; step(); wb_ready_i = 1'b0;
      vecs++; if (wb_valid_o !== 1'b0) begin
         errs++; $display("[TB] FAIL single_wb_drain: got wb_v=%b want 0", wb_valid_o); end
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < 3; i++) begin
         disp_valid_i = 1'b1; disp_wid_i = RID_W'(10 + i); disp_op_i = 2'(i);
         step();
      end
      disp_valid_i = 1'b0; div_ready_i = 1'b1;
      step(); step();
      vecs++; if (div_valid_o !== 1'b0 || div_wid_o !== 6'd12 || div_op_o !== 2'd2) begin
         errs++; $display("[TB] FAIL bp_stall: got v=%b wid=%0d op=%0d want 0 12 2", div_valid_o, div_wid_o, div_op_o); end
      step();
      vecs++; if (div_valid_o !== 1'b0) begin
         errs++; $display("[TB] FAIL bp_stall_hold: got div_v=%b want 0", div_valid_o); end
      div_ready_i = 1'b0; rsp_valid_i = 1'b1; rsp_wid_i = 6'd10; rsp_result_i = 32'd1;
      step(); rsp_valid_i = 1'b0;
      vecs++; if (div_valid_o !== 1'b1 || div_wid_o !== 6'd12 || wb_wid_o !== 6'd10) begin
         errs++; $display("[TB] FAIL bp_freed: got v=%b wid=%0d wb_wid=%0d want 1 12 10", div_valid_o, div_wid_o, wb_wid_o); end
      div_ready_i = 1'b1; step(); div_ready_i = 1'b0;
      wb_ready_i = 1'b1;
      for (int i = 1; i < 3; i++) begin
         rsp_valid_i = 1'b1; rsp_wid_i = RID_W'(10 + i); rsp_result_i = 32'(i + 1);
         step();
         vecs++; if (wb_valid_o !== 1'b1 || wb_wid_o !== RID_W'(10 + i) || wb_result_o !== 32'(i + 1)) begin
            errs++; $display("[TB] FAIL bp_wb%0d: got v=%b wid=%0d res=%0d want 1 %0d %0d", i, wb_valid_o, wb_wid_o, wb_result_o, 10 + i, i + 1); end
      end
      rsp_valid_i = 1'b0; step(); wb_ready_i = 1'b0;
      vecs++; if (wb_valid_o !== 1'b0 || err_o !== 1'b0) begin
         errs++; $display("[TB] FAIL bp_end: got wb_v=%b err=%b want 0 0", wb_valid_o, err_o); end
   endtask

   task automatic test_full_fifo();
      for (int i = 0; i < 4; i++) begin
         disp_valid_i = 1'b1; disp_wid_i = RID_W'(20 + i); disp_r1_i = 32'(1000 + i);
         step();
      end
      disp_wid_i = 6'd24; disp_r1_i = 32'd1004;
      vecs++; if (disp_ready_o !== 1'b0 || div_wid_o !== 6'd20 || div_r1_o !== 32'd1000) begin
         errs++; $display("[TB] FAIL full_rdy: got drdy=%b wid=%0d r1=%0d want 0 20 1000", disp_ready_o, div_wid_o, div_r1_o); end
      step();
      vecs++; if (disp_ready_o !== 1'b0 || div_wid_o !== 6'd20) begin
         errs++; $display("[TB] FAIL full_hold: got drdy=%b wid=%0d want 0 20", disp_ready_o, div_wid_o); end
      div_ready_i = 1'b1; step();
      vecs++; if (disp_ready_o !== 1'b1 || div_wid_o !== 6'd21) begin
         errs++; $display("[TB] FAIL full_pop_noslot: got drdy=%b wid=%0d want 1 21", disp_ready_o, div_wid_o); end
      step(); disp_valid_i = 1'b0;
      vecs++; if (div_valid_o !== 1'b0 || div_wid_o !== 6'd22) begin
         errs++; $display("[TB] FAIL full_maxout: got v=%b wid=%0d want 0 22", div_valid_o, div_wid_o); end
      wb_ready_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         rsp_valid_i = 1'b1; rsp_wid_i = RID_W'(20 + i); rsp_result_i = 32'(i * 3);
         step();
         vecs++; if (wb_valid_o !== 1'b1 || wb_wid_o !== RID_W'(20 + i) || wb_result_o !== 32'(i * 3)) begin
            errs++; $display("[TB] FAIL full_order%0d: got v=%b wid=%0d res=%0d want 1 %0d %0d", i, wb_valid_o, wb_wid_o, wb_result_o, 20 + i, i * 3); end
      end
      rsp_valid_i = 1'b0; div_ready_i = 1'b0; step(); wb_ready_i = 1'b0;
      vecs++; if (wb_valid_o !== 1'b0 || div_valid_o !== 1'b0 || err_o !== 1'b0) begin
         errs++; $display("[TB] FAIL full_end: got wb_v=%b div_v=%b err=%b want 0 0 0", wb_valid_o, div_valid_o, err_o); end
   endtask

   task automatic test_wb_stall();
      div_ready_i = 1'b1;
      disp_valid_i = 1'b1; disp_wid_i = 6'd30; step();
      disp_wid_i = 6'd31; step();
      disp_valid_i = 1'b0; step(); div_ready_i = 1'b0;
      rsp_valid_i = 1'b1; rsp_wid_i = 6'd30; rsp_result_i = 32'h111; step();
      rsp_wid_i = 6'd31; rsp_result_i = 32'h222;
      for (int i = 0; i < 2; i++) begin
         vecs++; if (rsp_ready_o !== 1'b0 || wb_valid_o !== 1'b1 || wb_wid_o !== 6'd30 || wb_result_o !== 32'h111) begin
            errs++; $display("[TB] FAIL stall_hold%0d: got rrdy=%b v=%b wid=%0d res=%0h want 0 1 30 111", i, rsp_ready_o, wb_valid_o, wb_wid_o, wb_result_o); end
         step();
      end
      wb_ready_i = 1'b1; #1;
      vecs++; if (rsp_ready_o !== 1'b1) begin
         errs++; $display("[TB] FAIL stall_release_rdy: got rrdy=%b want 1", rsp_ready_o); end
      step(); rsp_valid_i = 1'b0;
      vecs++; if (wb_valid_o !== 1'b1 || wb_wid_o !== 6'd31 || wb_result_o !== 32'h222) begin
         errs++; $display("[TB] FAIL stall_next: got v=%b wid=%0d res=%0h want 1 31 222", wb_valid_o, wb_wid_o, wb_result_o); end
      step(); wb_ready_i = 1'b0;
      vecs++; if (wb_valid_o !== 1'b0 || err_o !== 1'b0) begin
         errs++; $display("[TB] FAIL stall_end: got v=%b err=%b want 0 0", wb_valid_o, err_o); end
   endtask

   task automatic test_flush();
      div_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         disp_valid_i = 1'b1; disp_wid_i = RID_W'(40 + i); step();
      end
      disp_valid_i = 1'b0;
      rsp_valid_i = 1'b1; rsp_wid_i = 6'd40; rsp_result_i = 32'd9; step(); rsp_valid_i = 1'b0;
      vecs++; if (wb_valid_o !== 1'b1 || div_valid_o !== 1'b1 || div_wid_o !== 6'd42) begin
         errs++; $display("[TB] FAIL pre_flush: got wb_v=%b div_v=%b wid=%0d want 1 1 42", wb_valid_o, div_valid_o, div_wid_o); end
      div_ready_i = 1'b0;
      flush_i = 1'b1; disp_valid_i = 1'b1; disp_wid_i = 6'd50;
      step(); flush_i = 1'b0; disp_valid_i = 1'b0;
      vecs++; if (div_valid_o !== 1'b0 || wb_valid_o !== 1'b0 || disp_ready_o !== 1'b1 || err_o !== 1'b0) begin
         errs++; $display("[TB] FAIL post_flush: got div_v=%b wb_v=%b drdy=%b err=%b want 0 0 1 0", div_valid_o, wb_valid_o, disp_ready_o, err_o); end
      step();
      vecs++; if (div_valid_o !== 1'b0) begin
         errs++; $display("[TB] FAIL flush_push_dropped: got div_v=%b want 0", div_valid_o); end
      disp_valid_i = 1'b1; disp_wid_i = 6'd2; step();
      disp_wid_i = 6'd6; step(); disp_valid_i = 1'b0;
      div_ready_i = 1'b1; step();
      vecs++; if (div_valid_o !== 1'b1 || div_wid_o !== 6'd6) begin
         errs++; $display("[TB] FAIL flush_outcnt_zero: got v=%b wid=%0d want 1 6", div_valid_o, div_wid_o); end
      div_ready_i = 1'b0; wb_ready_i = 1'b1;
      rsp_valid_i = 1'b1; rsp_wid_i = 6'd3; rsp_result_i = 32'd77; step(); rsp_valid_i = 1'b0;
      vecs++; if (err_o !== 1'b1 || wb_valid_o !== 1'b1 || wb_wid_o !== 6'd3 || wb_result_o !== 32'd77) begin
         errs++; $display("[TB] FAIL bad_order: got err=%b wb_v=%b wid=%0d res=%0d want 1 1 3 77", err_o, wb_valid_o, wb_wid_o, wb_result_o); end
      flush_i = 1'b1; step(); flush_i = 1'b0; step();
      vecs++; if (err_o !== 1'b1 || wb_valid_o !== 1'b0 || div_valid_o !== 1'b0) begin
         errs++; $display("[TB] FAIL err_sticky: got err=%b wb_v=%b div_v=%b want 1 0 0", err_o, wb_valid_o, div_valid_o); end
      wb_ready_i = 1'b0;
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      step(); step();
      rst_n = 1'b1;
      step();
      test_reset();
      test_single_op();
      test_backpressure();
      test_full_fifo();
      test_wb_stall();
      test_flush();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
